pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 107 ++++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with exception/branch/return redirect and a circular return-address stack.
// Latency: one cycle from request to pc; status pulses are registered; stall holds all state.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h8000_0180),
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic                           exc,
    input  logic                           branch_taken,
    input  logic [WIDTH-1:0]               branch_target,
    input  logic                           ret,
    input  logic                           call,
    output logic [WIDTH-1:0]               pc,
    output logic [WIDTH-1:0]               pc_plus4,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           align_err,
    output logic                           ras_underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] ras_count_q, ras_count_d;
    logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic             align_err_q, align_err_d;
    logic             ras_underflow_q, ras_underflow_d;

    logic accept;
    logic ras_nonempty;
    logic push;
    logic pop;

    assign pc_plus4      = pc_q + WIDTH'(4);
    assign pc            = pc_q;
    assign ras_count     = ras_count_q;
    assign align_err     = align_err_q;
    assign ras_underflow = ras_underflow_q;

    assign accept       = !exc && !stall;
    assign ras_nonempty = (ras_count_q != '0);
    assign push         = accept && call;
    assign pop          = accept && ret && ras_nonempty;

    always_comb begin
        pc_d            = pc_q;
        ras_count_d     = ras_count_q;
        top_ptr_d       = top_ptr_q;
        ras_d           = ras_q;
        align_err_d     = 1'b0;
        ras_underflow_d = 1'b0;

        if (exc) begin
            pc_d        = EXC_VECTOR;
            ras_count_d = '0;
        end else if (accept) begin
            if (branch_taken) begin
                pc_d        = {branch_target[WIDTH-1:2], 2'b00};
                align_err_d = (branch_target[1:0] != 2'b00);
            end else if (ret && ras_nonempty) begin
                pc_d = ras_q[top_ptr_q];
            end else begin
                pc_d = pc_plus4;
            end
            ras_underflow_d = ret && !ras_nonempty;

            // Call and ret together swap the top in place; a lone push wraps over the oldest entry.
            case ({push, pop})
                2'b10: begin
                    top_ptr_d        = top_ptr_q + PTR_W'(1);
                    ras_d[top_ptr_d] = pc_plus4;
                    if (ras_count_q != CNT_W'(RAS_DEPTH))
                        ras_count_d = ras_count_q + CNT_W'(1);
                end
                2'b01: begin
                    top_ptr_d   = top_ptr_q - PTR_W'(1);
                    ras_count_d = ras_count_q - CNT_W'(1);
                end
                2'b11: ras_d[top_ptr_q] = pc_plus4;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_VECTOR;
            ras_count_q     <= '0;
            top_ptr_q       <= '0;
            align_err_q     <= 1'b0;
            ras_underflow_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            pc_q            <= pc_d;
            ras_count_q     <= ras_count_d;
            top_ptr_q       <= top_ptr_d;
            align_err_q     <= align_err_d;
            ras_underflow_q <= ras_underflow_d;
            ras_q           <= ras_d;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a queue-based reference stack predicts every cycle.
module tb_pc_unit;
    localparam logic [31:0] EXC = 32'h8000_0180;
    localparam int          DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        align;
        logic        uf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, exc, branch_taken, ret, call;
    logic [31:0] branch_target;
    logic [31:0] pc, pc_plus4;
    logic [2:0]  ras_count;
    logic        align_err, ras_underflow;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    exp_t        sb[$];

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .exc(exc),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ret(ret), .call(call), .pc(pc), .pc_plus4(pc_plus4),
        .ras_count(ras_count), .align_err(align_err), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic i_stall, input logic i_exc,
                        input logic i_br, input logic [31:0] i_tgt,
                        input logic i_ret, input logic i_call);
        exp_t        e;
        exp_t        got;
        logic [31:0] p4;
        logic [31:0] top;
        logic        had;
        p4      = m_pc + 32'd4;
        e.align = 1'b0;
        e.uf    = 1'b0;
        if (i_exc) begin
            e.pc = EXC;
            m_stack.delete();
        end else if (i_stall) begin
            e.pc = m_pc;
        end else begin
            had = (m_stack.size() != 0);
            top = had ? m_stack[$] : 32'h0;
            if (i_ret) begin
                if (had) void'(m_stack.pop_back());
                else e.uf = 1'b1;
            end
            if (i_call) begin
                m_stack.push_back(p4);
                if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
            end
            if (i_br) begin
                e.pc    = {i_tgt[31:2], 2'b00};
                e.align = (i_tgt[1:0] != 2'b00);
            end else if (i_ret && had) begin
                e.pc = top;
            end else begin
                e.pc = p4;
            end
        end
        e.cnt = m_stack.size();
        m_pc  = e.pc;
        sb.push_back(e);

        stall = i_stall; exc = i_exc; branch_taken = i_br;
        branch_target = i_tgt; ret = i_ret; call = i_call;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, ".pc"},       pc,                    got.pc);
        check({tag, ".pc_plus4"}, pc_plus4,              got.pc + 32'd4);
        check({tag, ".count"},    {29'd0, ras_count},    got.cnt);
        check({tag, ".align"},    {31'd0, align_err},    {31'd0, got.align});
        check({tag, ".uf"},       {31'd0, ras_underflow},{31'd0, got.uf});
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; exc = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; ret = 1'b0; call = 1'b0;
        m_pc = 32'h0;
        #3;
        check("rst.pc",    pc,                 32'h0);
        check("rst.count", {29'd0, ras_count}, 32'h0);
        check("rst.align", {31'd0, align_err}, 32'h0);
        check("rst.uf",    {31'd0, ras_underflow}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Sequential fetch after reset
        idle("seq0"); idle("seq1"); idle("seq2");
        check("seq.pc_c", pc, 32'h0000_000C);

        // Call with jump, then return
        step("br100",   1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        step("jal400",  1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
        check("jal.pc",    pc,                 32'h400);
        check("jal.count", {29'd0, ras_count}, 32'd1);
        idle("body0"); idle("body1");
        step("ret104",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("ret.pc",    pc,                 32'h104);
        check("ret.count", {29'd0, ras_count}, 32'd0);

        // Five nested calls overflow a 4-deep stack, five returns underflow once
        for (int i = 1; i <= 5; i++)
            step($sformatf("call%0d", i), 1'b0, 1'b0, 1'b1, 32'(i) << 12, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++)
            step($sformatf("ret%0d", i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Stall holds pc and stack while a branch is pending
        step("push1", 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        step("unstall", 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        check("unstall.pc", pc, 32'h200);

        // Exception beats stall/branch and clears the stack
        step("push2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step("exc",   1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
        check("exc.pc",    pc,                 EXC);
        check("exc.count", {29'd0, ras_count}, 32'd0);

        // Misaligned branch target, then wrap-around
        step("mis203",  1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 1'b0);
        idle("mis_after");
        step("brtop",   1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        idle("wrap");
        check("wrap.pc", pc, 32'h0);

        // Call+ret combinations and a branch overriding a pop
        step("cr_empty", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step("call_a",   1'b0, 1'b0, 1'b1, 32'h800, 1'b0, 1'b1);
        step("cr_full",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step("br_pop",   1'b0, 1'b0, 1'b1, 32'h900, 1'b1, 1'b0);
        step("ret_last", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Reset mid-operation discards a pending redirect and push
        step("pre_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        branch_taken = 1'b1; branch_target = 32'h500; call = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mrst.pc",    pc,                 32'h0);
        check("mrst.count", {29'd0, ras_count}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_pc = 32'h0;
        m_stack.delete();
        idle("post_rst");
        check("post_rst.pc", pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
